// File: rtl/mixcolumns_pipe.sv
// AES MixColumns / InvMixColumns stage, 1 or 2 register stages with valid/ready flow control.
// Optional MIXCOLUMNS_BYPASS_EN adds i_bypass, which passes blocks through untransformed.

// Per-byte doublings of one column; byte positions are preserved.
module mixcolumns_xt (
  input  logic [31:0] i_col,
  output logic [31:0] o_x2,
  output logic [31:0] o_x4,
  output logic [31:0] o_x8
);

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  always_comb begin
    o_x2 = '0;
    o_x4 = '0;
    o_x8 = '0;
    for (int r = 0; r < 4; r++) begin
      o_x2[8*r +: 8] = xtime(i_col[8*r +: 8]);
      o_x4[8*r +: 8] = xtime(xtime(i_col[8*r +: 8]));
      o_x8[8*r +: 8] = xtime(xtime(xtime(i_col[8*r +: 8])));
    end
  end

endmodule

// Circulant matrix combine for one column; row 0 sits in the column MSB.
module mixcolumns_comb (
  input  logic [31:0] i_b,
  input  logic [31:0] i_x2,
  input  logic [31:0] i_x4,
  input  logic [31:0] i_x8,
  input  logic        i_inv,
  input  logic        i_bypass,
  output logic [31:0] o_col
);

  function automatic logic [7:0] byt(input logic [31:0] w, input int idx);
    return w[31-8*idx -: 8];
  endfunction

  always_comb begin
    logic [7:0] fwd;
    logic [7:0] inv;
    int r1;
    int r2;
    int r3;
    o_col = '0;
    for (int r = 0; r < 4; r++) begin
      r1 = (r + 1) % 4;
      r2 = (r + 2) % 4;
      r3 = (r + 3) % 4;
      fwd = byt(i_x2, r) ^ byt(i_x2, r1) ^ byt(i_b, r1) ^ byt(i_b, r2) ^ byt(i_b, r3);
      inv = (byt(i_x8, r)  ^ byt(i_x4, r)  ^ byt(i_x2, r))
          ^ (byt(i_x8, r1) ^ byt(i_x2, r1) ^ byt(i_b, r1))
          ^ (byt(i_x8, r2) ^ byt(i_x4, r2) ^ byt(i_b, r2))
          ^ (byt(i_x8, r3) ^ byt(i_b, r3));
      if (i_bypass)
        o_col[31-8*r -: 8] = byt(i_b, r);
      else if (i_inv)
        o_col[31-8*r -: 8] = inv;
      else
        o_col[31-8*r -: 8] = fwd;
    end
  end

endmodule

module mixcolumns_pipe #(
  parameter int WORD   = 32,
  parameter int NB     = 4,
  parameter int STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic                 i_inv,
  input  logic [WORD*NB-1:0]   i_block,
`ifdef MIXCOLUMNS_BYPASS_EN
  input  logic                 i_bypass,
`endif
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 o_inv,
  output logic [WORD*NB-1:0]   o_block
);

  localparam int W = WORD * NB;

  logic         byp_in;
  logic [W-1:0] x2_w, x4_w, x8_w;
  logic [W-1:0] c_b, c_x2, c_x4, c_x8;
  logic [W-1:0] comb_w;
  logic         c_inv, c_byp;
  logic         src_valid;
  logic         out_adv;
  logic         out_load;

  logic         o_valid_q, o_valid_d;
  logic         o_inv_q, o_inv_d;
  logic [W-1:0] o_block_q, o_block_d;

`ifdef MIXCOLUMNS_BYPASS_EN
  assign byp_in = i_bypass;
`else
  assign byp_in = 1'b0;
`endif

  if (WORD != 32) begin : g_word_err
    $error("mixcolumns_pipe: WORD must be 32");
  end

  for (genvar c = 0; c < NB; c++) begin : g_col
    mixcolumns_xt u_xt (
      .i_col (i_block[WORD*(NB-c)-1 -: WORD]),
      .o_x2  (x2_w[WORD*(NB-c)-1 -: WORD]),
      .o_x4  (x4_w[WORD*(NB-c)-1 -: WORD]),
      .o_x8  (x8_w[WORD*(NB-c)-1 -: WORD])
    );
    mixcolumns_comb u_comb (
      .i_b      (c_b[WORD*(NB-c)-1 -: WORD]),
      .i_x2     (c_x2[WORD*(NB-c)-1 -: WORD]),
      .i_x4     (c_x4[WORD*(NB-c)-1 -: WORD]),
      .i_x8     (c_x8[WORD*(NB-c)-1 -: WORD]),
      .i_inv    (c_inv),
      .i_bypass (c_byp),
      .o_col    (comb_w[WORD*(NB-c)-1 -: WORD])
    );
  end

  if (STAGES == 1) begin : g_one
    assign c_b       = i_block;
    assign c_x2      = x2_w;
    assign c_x4      = x4_w;
    assign c_x8      = x8_w;
    assign c_inv     = i_inv;
    assign c_byp     = byp_in;
    assign src_valid = i_valid;
    assign o_ready   = out_adv;
  end else if (STAGES == 2) begin : g_two
    logic         a_valid_q, a_valid_d;
    logic         a_inv_q, a_inv_d;
    logic         a_byp_q, a_byp_d;
    logic [W-1:0] a_b_q, a_b_d;
    logic [W-1:0] a_x2_q, a_x2_d;
    logic [W-1:0] a_x4_q, a_x4_d;
    logic [W-1:0] a_x8_q, a_x8_d;
    logic         a_adv;
    logic         a_load;

    // Stage A may take a new block when empty or when its block moves on.
    always_comb begin
      a_adv     = !a_valid_q || out_adv;
      a_load    = i_valid && a_adv;
      a_valid_d = a_adv ? i_valid : a_valid_q;
      a_inv_d   = a_load ? i_inv   : a_inv_q;
      a_byp_d   = a_load ? byp_in  : a_byp_q;
      a_b_d     = a_load ? i_block : a_b_q;
      a_x2_d    = a_load ? x2_w    : a_x2_q;
      a_x4_d    = a_load ? x4_w    : a_x4_q;
      a_x8_d    = a_load ? x8_w    : a_x8_q;
    end

    always_ff @(posedge clk) begin
      if (!rst) begin
        a_valid_q <= 1'b0;
        a_inv_q   <= 1'b0;
        a_byp_q   <= 1'b0;
        a_b_q     <= '0;
        a_x2_q    <= '0;
        a_x4_q    <= '0;
        a_x8_q    <= '0;
      end else begin
        a_valid_q <= a_valid_d;
        a_inv_q   <= a_inv_d;
        a_byp_q   <= a_byp_d;
        a_b_q     <= a_b_d;
        a_x2_q    <= a_x2_d;
        a_x4_q    <= a_x4_d;
        a_x8_q    <= a_x8_d;
      end
    end

    assign c_b       = a_b_q;
    assign c_x2      = a_x2_q;
    assign c_x4      = a_x4_q;
    assign c_x8      = a_x8_q;
    assign c_inv     = a_inv_q;
    assign c_byp     = a_byp_q;
    assign src_valid = a_valid_q;
    assign o_ready   = a_adv;
  end else begin : g_stages_err
    $error("mixcolumns_pipe: STAGES must be 1 or 2");
  end

  // Output register; data only loads when a real block arrives.
  always_comb begin
    out_adv   = !o_valid_q || i_ready;
    out_load  = out_adv && src_valid;
    o_valid_d = out_adv ? src_valid : o_valid_q;
    o_inv_d   = out_load ? c_inv  : o_inv_q;
    o_block_d = out_load ? comb_w : o_block_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      o_valid_q <= 1'b0;
      o_inv_q   <= 1'b0;
      o_block_q <= '0;
    end else begin
      o_valid_q <= o_valid_d;
      o_inv_q   <= o_inv_d;
      o_block_q <= o_block_d;
    end
  end

  assign o_valid = o_valid_q;
  assign o_inv   = o_inv_q;
  assign o_block = o_block_q;

endmodule

// File: tb/tb_mixcolumns_pipe.sv
// Self-checking bench for mixcolumns_pipe: GF(2^8) reference model, scoreboard monitor and directed vectors.
module tb_mixcolumns_pipe;

  localparam int STAGES = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         i_valid = 1'b0;
  logic         i_inv = 1'b0;
  logic         i_bypass = 1'b0;
  logic         i_ready = 1'b1;
  logic [127:0] i_block = '0;
  logic         o_ready;
  logic         o_valid;
  logic         o_inv;
  logic [127:0] o_block;

  int total = 0;
  int bad   = 0;

  logic [127:0] exp_q[$];
  logic         expi_q[$];
  logic         was_rst = 1'b0;
  logic         prev_stall = 1'b0;
  logic [127:0] prev_blk = '0;
  logic         prev_inv = 1'b0;

  always #5 clk = ~clk;

  mixcolumns_pipe #(.WORD(32), .NB(4), .STAGES(STAGES)) dut (
    .clk     (clk),
    .rst     (rst),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_inv   (i_inv),
    .i_block (i_block),
`ifdef MIXCOLUMNS_BYPASS_EN
    .i_bypass(i_bypass),
`endif
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_inv   (o_inv),
    .o_block (o_block)
  );

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] m);
    logic [7:0] a;
    logic [7:0] p;
    a = a_in;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (m[i]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
    end
    return p;
  endfunction

  function automatic logic [127:0] model_mix(input logic [127:0] blk, input logic inv);
    logic [7:0]   row0[4];
    logic [7:0]   acc;
    logic [127:0] res;
    if (inv) row0 = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else     row0 = '{8'h02, 8'h03, 8'h01, 8'h01};
    res = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++)
          acc = acc ^ gmul(row0[(k - r + 4) % 4], blk[127-8*(4*c+k) -: 8]);
        res[127-8*(4*c+r) -: 8] = acc;
      end
    return res;
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] got, input logic [127:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Scoreboard: every negedge, compare outputs against the model queue and track transfers.
  always @(negedge clk) begin
    if (was_rst) begin
      checkOutput("rst_o_valid", o_valid, 0);
      checkOutput("rst_o_block", o_block, 0);
      checkOutput("rst_o_inv", o_inv, 0);
      checkOutput("rst_o_ready", o_ready, 1);
    end
    if (!rst) begin
      exp_q.delete();
      expi_q.delete();
      was_rst    = 1'b1;
      prev_stall = 1'b0;
    end else begin
      was_rst = 1'b0;
      if (prev_stall) begin
        checkOutput("stall_block", o_block, prev_blk);
        checkOutput("stall_valid_inv", {o_valid, o_inv}, {1'b1, prev_inv});
      end
      checkOutput("o_ready", o_ready, (exp_q.size() < STAGES) || i_ready);
      if (o_valid) begin
        if (exp_q.size() == 0) begin
          checkOutput("spurious_o_valid", o_valid, 0);
        end else begin
          checkOutput("o_block", o_block, exp_q[0]);
          checkOutput("o_inv", o_inv, expi_q[0]);
          if (i_ready) begin
            void'(exp_q.pop_front());
            void'(expi_q.pop_front());
          end
        end
      end
      prev_stall = o_valid && !i_ready;
      prev_blk   = o_block;
      prev_inv   = o_inv;
      if (i_valid && o_ready) begin
        exp_q.push_back(i_bypass ? i_block : model_mix(i_block, i_inv));
        expi_q.push_back(i_inv);
      end
    end
  end

  // Presents one block and holds it until accepted; leaves i_valid high.
  task automatic applyStimulus(input logic [127:0] blk, input logic inv, input logic byp);
    logic fire;
    int   n;
    i_block  = blk;
    i_inv    = inv;
    i_bypass = byp;
    i_valid  = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      fire = o_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!fire && n < 100);
    checkOutput("in_accept", fire, 1);
  endtask

  task automatic runDirected(input string name, input logic [127:0] blk, input logic inv,
                             input logic byp, input logic [127:0] want);
    i_ready = 1'b1;
    applyStimulus(blk, inv, byp);
    i_valid = 1'b0;
    repeat (STAGES - 1) begin
      @(negedge clk);
      checkOutput({name, "_early"}, o_valid, 0);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    checkOutput({name, "_valid"}, o_valid, 1);
    checkOutput(name, o_block, want);
    checkOutput({name, "_inv"}, o_inv, inv);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [127:0] fwd_vec, fwd_res, fips_in, fips_out, inv_in, inv_res;
    fwd_vec  = 128'hdb135345_f20a225c_c6c6c6c6_d4d4d4d5;
    fwd_res  = 128'h8e4da1bc_9fdc589d_c6c6c6c6_d5d5d7d6;
    inv_in   = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    inv_res  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    fips_in  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    fips_out = 128'h046681e5e0cb199a48f8d37a2806264c;

    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    checkOutput("model_fwd", model_mix(fwd_vec, 1'b0), fwd_res);
    checkOutput("model_inv", model_mix(inv_in, 1'b1), inv_res);
    checkOutput("model_fips", model_mix(fips_in, 1'b0), fips_out);

    runDirected("fwd_cols", fwd_vec, 1'b0, 1'b0, fwd_res);
    runDirected("inv_block", inv_in, 1'b1, 1'b0, inv_res);
    runDirected("fips_fwd", fips_in, 1'b0, 1'b0, fips_out);
    runDirected("fips_inv", fips_out, 1'b1, 1'b0, fips_in);

    $display("[TB] streaming with backpressure");
    fork
      begin
        for (int k = 0; k < 8; k++)
          applyStimulus(128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0 ^ {16{8'(k * 17)}}, k[0], 1'b0);
        i_valid = 1'b0;
      end
      begin
        for (int cyc = 0; cyc < 40; cyc++) begin
          i_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
          @(posedge clk);
          #1;
        end
        i_ready = 1'b1;
      end
    join
    begin
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 50) begin
        @(posedge clk);
        #1;
        n++;
      end
      checkOutput("drain_empty", exp_q.size(), 0);
    end

    $display("[TB] reset mid-flight");
    i_ready = 1'b0;
    applyStimulus(fips_in, 1'b0, 1'b0);
    applyStimulus(fwd_vec, 1'b1, 1'b0);
    i_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    i_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    runDirected("after_rst", fwd_vec, 1'b0, 1'b0, fwd_res);

`ifdef MIXCOLUMNS_BYPASS_EN
    runDirected("bypass", 128'h00112233445566778899aabbccddeeff, 1'b0, 1'b1,
                128'h00112233445566778899aabbccddeeff);
    runDirected("after_bypass", fips_in, 1'b0, 1'b0, fips_out);
`endif

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
